stall_flush_controller: RTL

Pipeline control block that consumes the per-cycle stall request from hazard detection and the taken-branch indication from EX, and turns them into the write-enable, flush and bubble controls of the PC, IF/ID and ID/EX registers. It enforces priority between simultaneous stall and flush events and sequences multi-cycle flushes. It also keeps saturating stall/flush performance counters and a sticky deadlock flag for stalls that never clear. It sits between the hazard detection unit and the pipeline register enables in the top-level datapath.

---
 rtl/stall_flush_controller.sv | 116 +++++++++++
 1 files changed

// File: rtl/stall_flush_controller.sv
// rtl/stall_flush_controller.sv - stall/flush priority, flush sequencing and perf counters
// Flush squashes a concurrent stall because the branch in EX is older than the ID instruction.
module stall_flush_controller #(
   parameter int FLUSH_CYCLES = 1,
   parameter int STALL_LIMIT  = 64,
   parameter int CNT_W        = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Stall_Req,
   input  logic             Branch_Taken,
   input  logic             Count_Clear,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Bubble,
   output logic [CNT_W-1:0] Stall_Count,
   output logic [CNT_W-1:0] Flush_Count,
   output logic             Deadlock
);

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

   localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
   localparam logic             MULTI_FLUSH  = (FLUSH_CYCLES > 1);
   localparam logic [15:0]      LIMIT        = 16'(STALL_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;

   state_t           state_q, state_d;
   logic [2:0]       fcnt_q, fcnt_d;
   logic [15:0]      scons_q, scons_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             deadlock_q, deadlock_d;
   logic             flush_cyc, stall_cyc;

   always_comb begin
      flush_cyc    = (state_q == FLUSH) || Branch_Taken;
      stall_cyc    = !flush_cyc && Stall_Req;

      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b0;
      if (Reset) begin
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else if (flush_cyc) begin
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else if (stall_cyc) begin
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b1;
      end

      state_d = state_q;
      fcnt_d  = fcnt_q;
      if (Branch_Taken) begin
         state_d = MULTI_FLUSH ? FLUSH : RUN;
         fcnt_d  = FLUSH_RELOAD;
      end else if (state_q == FLUSH) begin
         if (fcnt_q == 3'd0) begin
            state_d = RUN;
         end else begin
            fcnt_d = fcnt_q - 3'd1;
         end
      end else begin
         state_d = Stall_Req ? STALL : RUN;
      end

      // Any non-stall cycle breaks the consecutive run.
      scons_d = 16'd0;
      if (stall_cyc) begin
         scons_d = (scons_q >= LIMIT) ? LIMIT : scons_q + 16'd1;
      end

      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      deadlock_d  = deadlock_q;
      if (Count_Clear) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
         deadlock_d  = 1'b0;
      end else begin
         if (stall_cyc && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
         if (flush_cyc && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
         if (stall_cyc && scons_d == LIMIT)       deadlock_d  = 1'b1;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= RUN;
         fcnt_q      <= 3'd0;
         scons_q     <= 16'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         deadlock_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         fcnt_q      <= fcnt_d;
         scons_q     <= scons_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         deadlock_q  <= deadlock_d;
      end
   end

   assign Stall_Count = stall_cnt_q;
   assign Flush_Count = flush_cnt_q;
   assign Deadlock    = deadlock_q;

endmodule
